// File: rtl/indicador_necesidades_if.sv
// indicador_necesidades_if: need levels and care flags in, LED bars and buzzer out.
interface indicador_necesidades_if;
    logic [1:0] Nivel_Comida;
    logic [1:0] Nivel_Medicina;
    logic       Activo_Comida;
    logic       Activo_Medicina;
    logic [3:0] LED_Comida;
    logic [3:0] LED_Medicina;
    logic       Buzzer;
    logic       Alerta;
    modport master (
        output Nivel_Comida, Nivel_Medicina, Activo_Comida, Activo_Medicina,
        input  LED_Comida, LED_Medicina, Buzzer, Alerta
    );
    modport slave (
        input  Nivel_Comida, Nivel_Medicina, Activo_Comida, Activo_Medicina,
        output LED_Comida, LED_Medicina, Buzzer, Alerta
    );
endinterface

// File: rtl/indicador_necesidades.sv
// indicador_necesidades: need level bars with critical blink and a beep burst on each new critical need.
// Define BUZZER_EN to build the alert FSM and arming logic; otherwise Buzzer and Alerta stay 0.
module indicador_necesidades #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int BLINK_HZ    = 2,
    parameter int ALERT_BEEPS = 3
) (
    input logic clk,
    input logic reset,
    indicador_necesidades_if.slave bus
);
    localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int CW   = $clog2(HALF);
    if (HALF < 2 || ALERT_BEEPS < 1 || ALERT_BEEPS > 15) begin : g_bad_params
        $error("indicador_necesidades: HALF must be >= 2 and ALERT_BEEPS in 1..15");
    end
    logic [CW-1:0] cnt;
    logic          fase;
    function automatic logic [3:0] barra(input logic act, input logic [1:0] lvl, input logic f);
        return act ? 4'b1111 : lvl == 2'd3 ? 4'b0111 : lvl == 2'd2 ? 4'b0011 :
               lvl == 2'd1 ? 4'b0001 : {3'b000, f};
    endfunction
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt              <= '0;
            fase             <= 1'b0;
            bus.LED_Comida   <= '0;
            bus.LED_Medicina <= '0;
        end else begin
            cnt              <= cnt == CW'(HALF - 1) ? '0 : cnt + 1'b1;
            fase             <= cnt == CW'(HALF - 1) ? ~fase : fase;
            bus.LED_Comida   <= barra(bus.Activo_Comida, bus.Nivel_Comida, fase);
            bus.LED_Medicina <= barra(bus.Activo_Medicina, bus.Nivel_Medicina, fase);
        end
    end
`ifdef BUZZER_EN
    typedef enum logic [1:0] {IDLE, BEEP_ON, BEEP_OFF} estado_t;
    estado_t       estado, estado_n;
    logic [CW-1:0] ph, ph_n;
    logic [3:0]    beeps, beeps_n;
    logic          armado_c, armado_m;
    logic          trig_c, trig_m;
    assign trig_c = bus.Nivel_Comida == 2'd0 && armado_c && !bus.Activo_Comida;
    assign trig_m = bus.Nivel_Medicina == 2'd0 && armado_m && !bus.Activo_Medicina;
    always_comb begin
        estado_n = estado;
        ph_n     = ph;
        beeps_n  = beeps;
        if (estado == IDLE) begin
            if (trig_c || trig_m) begin
                estado_n = BEEP_ON;
                ph_n     = '0;
                beeps_n  = '0;
            end
        end else if (bus.Activo_Comida || bus.Activo_Medicina) begin
            estado_n = IDLE;
        end else if (ph == CW'(HALF - 1)) begin
            ph_n     = '0;
            beeps_n  = estado == BEEP_OFF ? beeps + 4'd1 : beeps;
            estado_n = estado == BEEP_ON ? BEEP_OFF : beeps_n == 4'(ALERT_BEEPS) ? IDLE : BEEP_ON;
        end else begin
            ph_n = ph + 1'b1;
        end
    end
    // Outputs decode the current state, so they trail the state register by one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado     <= IDLE;
            ph         <= '0;
            beeps      <= '0;
            armado_c   <= 1'b1;
            armado_m   <= 1'b1;
            bus.Buzzer <= 1'b0;
            bus.Alerta <= 1'b0;
        end else begin
            estado     <= estado_n;
            ph         <= ph_n;
            beeps      <= beeps_n;
            armado_c   <= bus.Nivel_Comida != 2'd0 ? 1'b1 : trig_c ? 1'b0 : armado_c;
            armado_m   <= bus.Nivel_Medicina != 2'd0 ? 1'b1 : trig_m ? 1'b0 : armado_m;
            bus.Buzzer <= estado == BEEP_ON;
            bus.Alerta <= estado != IDLE;
        end
    end
`else
    assign bus.Buzzer = 1'b0;
    assign bus.Alerta = 1'b0;
`endif
endmodule

// File: doc/indicador_necesidades.md
# indicador_necesidades

Output-side counterpart of the button/mode front end in the pet design. It consumes the food/medicine need levels and the state machine's care-active flags. It drives two 4-LED level bars and a buzzer, blinking a bar when its need is critical (level 0). It also sounds a fixed beep burst each time a need falls to critical.

## Interface
Parameters:
- CLK_HZ, 50_000_000: clock frequency in Hz.
- BLINK_HZ, 2: blink rate of a critical bar in Hz. HALF = CLK_HZ/(2*BLINK_HZ) cycles, and HALF must be ≥ 2.
- ALERT_BEEPS, 3: number of beeps per alert burst, range 1..15.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- Nivel_Comida, input, 2: food level, 0 = critical, 3 = full.
- Nivel_Medicina, input, 2: medicine level, 0 = critical, 3 = full.
- Activo_Comida, input, 1: a food care action is in progress.
- Activo_Medicina, input, 1: a medicine care action is in progress.
- LED_Comida, output, 4: food bar, registered.
- LED_Medicina, output, 4: medicine bar, registered.
- Buzzer, output, 1: buzzer drive, registered.
- Alerta, output, 1: high while an alert burst is running, registered.

## Operation
- Blink prescaler: a counter runs 0..HALF-1. At HALF-1 it wraps to 0 and toggles `fase`. Reset clears the counter and `fase`.
- Bar mapping, evaluated independently per need:
  - Activo high → 4'b1111 (steady).
  - Otherwise level 3 → 4'b0111, level 2 → 4'b0011, level 1 → 4'b0001.
  - Otherwise level 0 → {3'b000, fase}.
- Activo takes priority over the level.
- Arming: each need has an `armado` bit.
  - Reset sets it to 1.
  - It is set to 1 whenever the level is ≠ 0.
  - It is cleared when that need triggers.
- Trigger: a need triggers when its level == 0, its armado == 1 and its Activo == 0.
- Alert FSM:
  - IDLE: Buzzer = 0, Alerta = 0. Any trigger → BEEP_ON, with beep counter = 0 and phase counter = 0.
  - BEEP_ON: Buzzer = 1, Alerta = 1. After HALF cycles → BEEP_OFF.
  - BEEP_OFF: Buzzer = 0, Alerta = 1. After HALF cycles, increment the beep counter. If it equals ALERT_BEEPS → IDLE, else → BEEP_ON.
  - Abort: Activo_Comida or Activo_Medicina high while in BEEP_ON or BEEP_OFF → IDLE on the next edge.
- The FSM's own phase counter is independent of the blink prescaler.
- Simultaneous events:
  - Both needs triggering in the same cycle produce a single burst, and both armado bits are cleared.
  - A trigger while the FSM is not IDLE clears that armado bit and does not start or extend a burst.
- Reset mid-burst: the FSM returns to IDLE with Buzzer = 0 in the same edge. armado goes to 1, so a level still at 0 re-triggers one cycle after reset deasserts.

## Timing
- Reset values: LED_Comida = 0, LED_Medicina = 0, Buzzer = 0, Alerta = 0, fase = 0, all counters = 0, FSM = IDLE.
- Bar latency: 1 cycle from an input change to the LED output.
- Blink: a critical bar's LSB toggles every HALF cycles, giving period 2·HALF.
- Trigger latency: level 0 sampled at edge N → FSM in BEEP_ON after edge N, and Buzzer/Alerta are 1 from edge N+1.
- Burst length: 2·HALF·ALERT_BEEPS cycles of Alerta = 1, with Buzzer high for HALF cycles and low for HALF cycles per beep.
- Abort latency: Buzzer and Alerta are 0 one cycle after Activo is sampled high.

## Configuration
- BUZZER_EN defined: the alert FSM, arming logic, Buzzer and Alerta behave as specified above.
- BUZZER_EN undefined: the FSM and armado logic are not compiled. Buzzer and Alerta are constant 0, and bar and blink behaviour is unchanged.

## Test plan
All scenarios use CLK_HZ = 8 and BLINK_HZ = 1, giving HALF = 4, with ALERT_BEEPS = 3 and BUZZER_EN defined.
- Reset held 3 cycles with levels 3/2 → all outputs 0 during reset. One cycle after release, LED_Comida = 0111 and LED_Medicina = 0011.
- Nivel_Comida 1 → 0 → exactly 3 beeps (4 cycles high, 4 low) and Alerta high for 24 cycles. LED_Comida toggles 0000/0001 every 4 cycles. No second burst while the level stays 0.
- Both levels go to 0 in the same cycle → one 24-cycle burst only.
- Activo_Medicina pulsed high during beep 2 → Buzzer/Alerta 0 on the next cycle and LED_Medicina = 1111 while high. Level 0 → 1 → 0 afterwards produces a new burst.
- Reset asserted mid-burst with levels still 0 → Buzzer 0 during reset, and a fresh burst starts 1 cycle after release.
- BUZZER_EN undefined, level 0 → Buzzer = Alerta = 0 throughout, and the LED bar blinks as specified.
